// File: rtl/timer_pkg.sv
// Shared constants and helpers for the BCD timer display.
//   SEG_0..SEG_9 / SEG_BLANK : active-low 7-segment patterns, bit 6 = a .. bit 0 = g
//   AN_OFF                    : all anodes released (common-anode, active-low)
//   BCD_MAX                   : largest legal BCD digit
//   seg_decode()              : BCD digit to segment pattern, non-BCD codes go blank
//   bcd_sat()                 : clamps a nibble to 0..9
package timer_pkg;

  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_timer_display_if.sv
// Board-side bundle of the BCD timer display.
//   master : drives en, up_down, load, load_val; observes count, wrap, seg, an
//   slave  : the timer itself
//   en        1 = prescaler runs
//   up_down   1 = count up, 0 = count down
//   load      synchronous load strobe, load_val nibble i = digit i
//   count     current BCD count, wrap one-cycle wrap-around pulse
//   seg / an  active-low segment and anode drives
interface bcd_timer_display_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up_down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic [6:0]            seg;
  logic [7:0]            an;

  modport master (
    output en, up_down, load, load_val,
    input  count, wrap, seg, an
  );

  modport slave (
    input  en, up_down, load, load_val,
    output count, wrap, seg, an
  );
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit of the timer chain.
//   clk, reset  clock and asynchronous active-low reset
//   load        take load_nib (clamped to 9), overrides stepping
//   load_nib    digit load value
//   step        count-step strobe from the prescaler
//   up_down     1 = increment, 0 = decrement
//   cin         carry (up) / borrow (down) from all lower digits
//   digit       current value
//   cout        carry/borrow into the next digit
module bcd_digit
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_nib,
  input  logic       step,
  input  logic       up_down,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  // Ripple passes through only when this digit is about to roll over.
  assign cout = cin & (up_down ? (digit == BCD_MAX) : (digit == 4'd0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= bcd_sat(load_nib);
    end else if (step && cin) begin
      if (up_down) digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
      else         digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_timer_display.sv
// N-digit BCD up/down timer with tick prescaler and multiplexed
// 7-segment driver for an 8-digit common-anode display.
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    bcd_timer_display_if.slave (en, up_down, load, load_val,
//          count, wrap, seg, an)
// Optional build macro LEADING_ZERO_BLANK_EN: blanks zero digits that
// have only zeros above them (digit 0 is always shown).
module bcd_timer_display
  import timer_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 25000000,
  parameter int SCAN_BITS = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_timer_display_if.slave   bus
);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_timer_display: DIGITS must be in 1..8");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("bcd_timer_display: TICK_DIV must be >= 2");
  end
  if (SCAN_BITS < 3) begin : g_bad_scan
    $error("bcd_timer_display: SCAN_BITS must be >= 3");
  end

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]        presc;
  logic                 step;
  logic [DIGITS:0]      carry;
  logic [3:0]           digit [DIGITS];
  logic [4*DIGITS-1:0]  count_flat;
  logic                 wrap_q;
  logic [SCAN_BITS-1:0] scan_p0;
  logic [2:0]           slot_p0;
  logic [3:0]           sel_digit;
  logic                 sel_blank;
  logic [6:0]           seg_p1;
  logic [7:0]           an_p1;

  // Load wins over a coincident tick, so the tick is suppressed here.
  assign step     = bus.en & ~bus.load & (presc == PRESC_LAST);
  assign carry[0] = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           presc <= '0;
    else if (bus.load)    presc <= '0;
    else if (bus.en)      presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .load     (bus.load),
      .load_nib (bus.load_val[4*g +: 4]),
      .step     (step),
      .up_down  (bus.up_down),
      .cin      (carry[g]),
      .digit    (digit[g]),
      .cout     (carry[g+1])
    );
    assign count_flat[4*g +: 4] = digit[g];
  end

  // A carry out of the top digit on a step edge is exactly a wrap-around.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrap_q <= 1'b0;
    else        wrap_q <= step & carry[DIGITS];
  end

  // Stage p0: free-running scan counter, slot from its top three bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) scan_p0 <= '0;
    else        scan_p0 <= scan_p0 + SCAN_BITS'(1);
  end

  assign slot_p0 = scan_p0[SCAN_BITS-1 -: 3];

  always_comb begin
    sel_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (slot_p0 == 3'(i)) sel_digit = digit[i];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;
  logic              above_zero;

  // Walk from the top digit down; a digit is a leading zero while every
  // digit above it is also zero. Digit 0 is excluded so "0" stays visible.
  always_comb begin
    above_zero = 1'b1;
    lead_zero  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      above_zero   = above_zero & (digit[i] == 4'd0);
      lead_zero[i] = above_zero & (i != 0);
    end
  end

  always_comb begin
    sel_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (slot_p0 == 3'(i)) sel_blank = lead_zero[i];
    end
  end
`else
  assign sel_blank = 1'b0;
`endif

  // Stage p1: registered anode/segment drive, one clock behind the scan
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_p1  <= AN_OFF;
      seg_p1 <= SEG_BLANK;
    end else if (int'(slot_p0) < DIGITS) begin
      an_p1  <= ~(8'b1 << slot_p0);
      seg_p1 <= sel_blank ? SEG_BLANK : seg_decode(sel_digit);
    end else begin
      an_p1  <= AN_OFF;
      seg_p1 <= SEG_BLANK;
    end
  end

  assign bus.count = count_flat;
  assign bus.wrap  = wrap_q;
  assign bus.seg   = seg_p1;
  assign bus.an    = an_p1;

endmodule

// File: tb/tb_bcd_timer_display.sv
// Bench for bcd_timer_display (DIGITS=4, TICK_DIV=4, SCAN_BITS=6).
// Keeps an integer-valued model of the timer and display and compares
// every DUT output against it on each falling edge, plus fixed literal
// expectations for the directed scenarios.
module tb_bcd_timer_display;

  localparam int DIGITS    = 4;
  localparam int TICK_DIV  = 4;
  localparam int SCAN_BITS = 6;
  localparam int MAXV      = 10 ** DIGITS;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  bcd_timer_display_if #(.DIGITS(DIGITS)) bus ();

  bcd_timer_display #(
    .DIGITS    (DIGITS),
    .TICK_DIV  (TICK_DIV),
    .SCAN_BITS (SCAN_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] seg_tab [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                               7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

  // Model state: count as a plain integer, prescaler phase, scan cycle.
  int         m_cnt;
  int         m_presc;
  int         m_scan;
  logic       m_wrap;
  logic [6:0] m_seg;
  logic [7:0] m_an;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic int bcd_to_int(input logic [4*DIGITS-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      int n = int'(v[4*i +: 4]);
      if (n > 9) n = 9;
      r = r * 10 + n;
    end
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] int_to_bcd(input int v);
    logic [4*DIGITS-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_presc = 0;
    m_scan  = 0;
    m_wrap  = 1'b0;
    m_seg   = 7'h7F;
    m_an    = 8'hFF;
  endtask

  task automatic model_step();
    int slot;
    slot = m_scan >> (SCAN_BITS - 3);
    if (slot < DIGITS) begin
      m_an  = ~(8'h01 << slot);
      m_seg = seg_tab[(m_cnt / (10 ** slot)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (slot > 0 && m_cnt < 10 ** slot) m_seg = 7'h7F;
`endif
    end else begin
      m_an  = 8'hFF;
      m_seg = 7'h7F;
    end
    m_wrap = 1'b0;
    if (bus.load) begin
      m_cnt   = bcd_to_int(bus.load_val);
      m_presc = 0;
    end else if (bus.en) begin
      if (m_presc == TICK_DIV - 1) begin
        m_presc = 0;
        if (bus.up_down) begin
          m_wrap = (m_cnt == MAXV - 1);
          m_cnt  = (m_cnt + 1) % MAXV;
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + MAXV - 1) % MAXV;
        end
      end else begin
        m_presc++;
      end
    end
    m_scan = (m_scan + 1) % (1 << SCAN_BITS);
  endtask

  initial model_reset();

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("count", 32'(bus.count), 32'(int_to_bcd(m_cnt)));
    chk("wrap",  32'(bus.wrap),  32'(m_wrap));
    chk("seg",   32'(bus.seg),   32'(m_seg));
    chk("an",    32'(bus.an),    32'(m_an));
  end

  task automatic do_load(input logic [4*DIGITS-1:0] v);
    bus.load_val = v;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.en       = 1'b0;
    bus.up_down  = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = '0;

    #1 reset = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_an",    32'(bus.an),    32'hFF);
    chk("rst_seg",   32'(bus.seg),   32'h7F);
    chk("rst_wrap",  32'(bus.wrap),  32'h0);
    tick(3);

    // Count up from reset: first step after TICK_DIV clocks.
    reset  = 1'b1;
    bus.en = 1'b1;
    tick(4);
    chk("up_first", 32'(bus.count), 32'h0001);
    tick(36);
    chk("up_40clk", 32'(bus.count), 32'h0010);

    // Up wrap 9998 -> 9999 -> 0000.
    do_load(16'h9998);
    tick(4);
    chk("up_9999", 32'(bus.count), 32'h9999);
    chk("up_9999_wrap", 32'(bus.wrap), 32'h0);
    tick(4);
    chk("up_wrap_cnt", 32'(bus.count), 32'h0000);
    chk("up_wrap_pulse", 32'(bus.wrap), 32'h1);
    tick(1);
    chk("up_wrap_end", 32'(bus.wrap), 32'h0);

    // Down wrap 0001 -> 0000 -> 9999.
    bus.up_down = 1'b0;
    do_load(16'h0001);
    tick(4);
    chk("dn_0000", 32'(bus.count), 32'h0000);
    tick(4);
    chk("dn_wrap_cnt", 32'(bus.count), 32'h9999);
    chk("dn_wrap_pulse", 32'(bus.wrap), 32'h1);

    // Saturating load, then freeze with en=0.
    do_load(16'h00A3);
    chk("load_sat", 32'(bus.count), 32'h0093);
    bus.en = 1'b0;
    tick(20);
    chk("hold_cnt", 32'(bus.count), 32'h0093);
    bus.en = 1'b1;
    tick(3);
    chk("resume_pre", 32'(bus.count), 32'h0093);
    tick(1);
    chk("resume_step", 32'(bus.count), 32'h0092);

    // Load coincident with a step that would otherwise wrap down.
    do_load(16'h0000);
    tick(3);
    do_load(16'h0456);
    chk("coinc_cnt", 32'(bus.count), 32'h0456);
    chk("coinc_wrap", 32'(bus.wrap), 32'h0);

    // Scan of 0123 across all eight slots.
    bus.en = 1'b0;
    do_load(16'h0123);
    tick(1);
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      case (bus.an)
        8'hFE: chk("scan_s0", 32'(bus.seg), 32'h06);
        8'hFD: chk("scan_s1", 32'(bus.seg), 32'h12);
        8'hFB: chk("scan_s2", 32'(bus.seg), 32'h4F);
`ifdef LEADING_ZERO_BLANK_EN
        8'hF7: chk("scan_s3", 32'(bus.seg), 32'h7F);
`else
        8'hF7: chk("scan_s3", 32'(bus.seg), 32'h01);
`endif
        8'hFF: chk("scan_off", 32'(bus.seg), 32'h7F);
        default: chk("scan_an", 32'(bus.an), 32'hFF);
      endcase
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.en      = ($urandom_range(0, 7) != 0);
      bus.up_down = ($urandom_range(0, 15) != 0) ? bus.up_down : ~bus.up_down;
      bus.load    = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       bus.load_val = 16'h9997;
        1:       bus.load_val = 16'h0002;
        default: bus.load_val = 16'($urandom);
      endcase
      @(negedge clk);
    end
    bus.load = 1'b0;
    bus.en   = 1'b1;
    tick(10);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 32'h0);
    chk("arst_an",    32'(bus.an),    32'hFF);
    chk("arst_seg",   32'(bus.seg),   32'h7F);
    chk("arst_wrap",  32'(bus.wrap),  32'h0);
    tick(2);
    reset = 1'b1;
    tick(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
